// File: rtl/vga_pkg.sv
// Shared VGA definitions: default active area, colour width, sync polarity,
// packed RGB type and the box movement direction type.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int COLOR_W      = 4;
    localparam int RGB_W        = 3 * COLOR_W;
    localparam int CNT_W        = 10;
    localparam int BCNT_W       = 8;

    localparam logic SYNC_ACTIVE = 1'b0;
    localparam logic SYNC_IDLE   = 1'b1;

    typedef logic [RGB_W-1:0] rgb_t;

    typedef enum logic {
        DIR_DEC = 1'b0,
        DIR_INC = 1'b1
    } dir_e;

    function automatic rgb_t rgb_gate(input logic on, input rgb_t colour);
        return on ? colour : '0;
    endfunction

endpackage

// File: rtl/vga_bounce_box_if.sv
// Pixel-side bundle between the VGA timing generator / pins and vga_bounce_box.
// The master drives timing and freeze, the slave returns colour, syncs and count.
interface vga_bounce_box_if;

    logic                         pix_en_i;
    logic [vga_pkg::CNT_W-1:0]    hcount_i;
    logic [vga_pkg::CNT_W-1:0]    vcount_i;
    logic                         blank_i;
    logic                         hs_i;
    logic                         vs_i;
    logic                         freeze_i;
    logic [vga_pkg::COLOR_W-1:0]  red_o;
    logic [vga_pkg::COLOR_W-1:0]  green_o;
    logic [vga_pkg::COLOR_W-1:0]  blue_o;
    logic                         hs_o;
    logic                         vs_o;
    logic [vga_pkg::BCNT_W-1:0]   bounce_cnt_o;

    modport master (
        output pix_en_i, hcount_i, vcount_i, blank_i, hs_i, vs_i, freeze_i,
        input  red_o, green_o, blue_o, hs_o, vs_o, bounce_cnt_o
    );

    modport slave (
        input  pix_en_i, hcount_i, vcount_i, blank_i, hs_i, vs_i, freeze_i,
        output red_o, green_o, blue_o, hs_o, vs_o, bounce_cnt_o
    );

endinterface

// File: rtl/vga_axis_bounce.sv
// One-axis box mover: steps the position once per enabled frame and reverses
// direction at the edges, clamping to [0, EXTENT-SIZE].
module vga_axis_bounce
    import vga_pkg::*;
#(
    parameter int EXTENT = H_ACTIVE_DEF,
    parameter int SIZE   = 20,
    parameter int STEP   = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             adv,
    output logic [CNT_W-1:0] pos,
    output logic             bounce
);

    localparam int PW = CNT_W + 1;
    localparam logic [PW-1:0]    HI_TURN = PW'(EXTENT - SIZE - STEP);
    localparam logic [PW-1:0]    LO_TURN = PW'(STEP);
    localparam logic [CNT_W-1:0] POS_MAX = CNT_W'(EXTENT - SIZE);
    localparam logic [CNT_W-1:0] STEP_V  = CNT_W'(STEP);

    logic [CNT_W-1:0] pos_q;
    logic [CNT_W-1:0] pos_nxt;
    dir_e             dir_q;
    dir_e             dir_nxt;
    logic             turn;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pos_q <= '0;
            dir_q <= DIR_INC;
        end else if (adv) begin
            pos_q <= pos_nxt;
            dir_q <= dir_nxt;
        end
    end

    // Thresholds are compared one bit wider so the turn test never wraps.
    always_comb begin
        pos_nxt = pos_q;
        dir_nxt = dir_q;
        turn    = 1'b0;
        if (dir_q == DIR_INC) begin
            if ({1'b0, pos_q} >= HI_TURN) begin
                pos_nxt = POS_MAX;
                dir_nxt = DIR_DEC;
                turn    = 1'b1;
            end else begin
                pos_nxt = pos_q + STEP_V;
            end
        end else begin
            if ({1'b0, pos_q} <= LO_TURN) begin
                pos_nxt = '0;
                dir_nxt = DIR_INC;
                turn    = 1'b1;
            end else begin
                pos_nxt = pos_q - STEP_V;
            end
        end
    end

    always_comb begin
        pos    = pos_q;
        bounce = adv & turn;
    end

endmodule

// File: rtl/vga_bounce_box.sv
// Draws a solid box that moves one step per frame and bounces off the edges,
// with hs/vs re-timed to the registered RGB. Optional outline: VGA_BOUNCE_BORDER_EN.
module vga_bounce_box
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_DEF,
    parameter int   V_ACTIVE = V_ACTIVE_DEF,
    parameter int   BOX_W    = 20,
    parameter int   BOX_H    = 20,
    parameter int   STEP     = 1,
    parameter rgb_t BOX_RGB  = 12'hFFF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    vga_bounce_box_if.slave   bus
);

    localparam int PW = CNT_W + 1;
    localparam logic [PW-1:0] BOX_W_V = PW'(BOX_W);
    localparam logic [PW-1:0] BOX_H_V = PW'(BOX_H);

    logic              vs_prev_p0;
    logic              tick;
    logic              adv;
    logic [CNT_W-1:0]  x_pos;
    logic [CNT_W-1:0]  y_pos;
    logic              bounce_x;
    logic              bounce_y;
    logic              in_x;
    logic              in_y;
    logic              pixel_on;
    rgb_t              rgb_p1;
    logic              hs_p1;
    logic              vs_p1;
    logic [BCNT_W-1:0] cnt_p1;

    // Frame tick: sync falling edge seen across two consecutive strobes.
    assign tick = bus.pix_en_i & (vs_prev_p0 == SYNC_IDLE) & (bus.vs_i == SYNC_ACTIVE);
    assign adv  = tick & ~bus.freeze_i;

    vga_axis_bounce #(
        .EXTENT (H_ACTIVE),
        .SIZE   (BOX_W),
        .STEP   (STEP)
    ) u_axis_x (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .adv    (adv),
        .pos    (x_pos),
        .bounce (bounce_x)
    );

    vga_axis_bounce #(
        .EXTENT (V_ACTIVE),
        .SIZE   (BOX_H),
        .STEP   (STEP)
    ) u_axis_y (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .adv    (adv),
        .pos    (y_pos),
        .bounce (bounce_y)
    );

    always_comb begin
        in_x = ({1'b0, bus.hcount_i} >= {1'b0, x_pos}) &&
               ({1'b0, bus.hcount_i} <  ({1'b0, x_pos} + BOX_W_V));
        in_y = ({1'b0, bus.vcount_i} >= {1'b0, y_pos}) &&
               ({1'b0, bus.vcount_i} <  ({1'b0, y_pos} + BOX_H_V));
    end

`ifdef VGA_BOUNCE_BORDER_EN
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE - 1);
    logic border;

    always_comb begin
        border = (bus.hcount_i == '0) || (bus.hcount_i == H_LAST) ||
                 (bus.vcount_i == '0) || (bus.vcount_i == V_LAST);
        pixel_on = ~bus.blank_i & ((in_x & in_y) | border);
    end
`else
    always_comb begin
        pixel_on = ~bus.blank_i & in_x & in_y;
    end
`endif

    // Stage p1: output registers, one strobe behind the timing inputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rgb_p1     <= '0;
            hs_p1      <= SYNC_IDLE;
            vs_p1      <= SYNC_IDLE;
            vs_prev_p0 <= SYNC_IDLE;
            cnt_p1     <= '0;
        end else if (bus.pix_en_i) begin
            rgb_p1     <= rgb_gate(pixel_on, BOX_RGB);
            hs_p1      <= bus.hs_i;
            vs_p1      <= bus.vs_i;
            vs_prev_p0 <= bus.vs_i;
            if (bounce_x | bounce_y)
                cnt_p1 <= cnt_p1 + 1'b1;
        end
    end

    assign bus.red_o        = rgb_p1[3*COLOR_W-1:2*COLOR_W];
    assign bus.green_o      = rgb_p1[2*COLOR_W-1:COLOR_W];
    assign bus.blue_o       = rgb_p1[COLOR_W-1:0];
    assign bus.hs_o         = hs_p1;
    assign bus.vs_o         = vs_p1;
    assign bus.bounce_cnt_o = cnt_p1;

endmodule

// File: tb/tb_vga_bounce_box.sv
// Directed bench for vga_bounce_box: a 640x480 instance and a 64x64 instance
// driven with the same compressed frames (one vsync edge per frame).
module tb_vga_bounce_box;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    vga_bounce_box_if if_a ();
    vga_bounce_box_if if_b ();

    vga_bounce_box dut_a (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if_a)
    );

    vga_bounce_box #(
        .H_ACTIVE (64),
        .V_ACTIVE (64),
        .BOX_W    (8),
        .BOX_H    (8)
    ) dut_b (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if_b)
    );

    logic [11:0] rgb_a, rgb_b;
    assign rgb_a = {if_a.red_o, if_a.green_o, if_a.blue_o};
    assign rgb_b = {if_b.red_o, if_b.green_o, if_b.blue_o};

`ifdef VGA_BOUNCE_BORDER_EN
    localparam logic [11:0] EDGE_RGB = 12'hFFF;
`else
    localparam logic [11:0] EDGE_RGB = 12'h000;
`endif

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic [9:0] h, input logic [9:0] v,
                          input logic blank, input logic hs, input logic vs, input logic frz);
        if_a.hcount_i = h;  if_b.hcount_i = h;
        if_a.vcount_i = v;  if_b.vcount_i = v;
        if_a.blank_i  = blank; if_b.blank_i = blank;
        if_a.hs_i     = hs; if_b.hs_i = hs;
        if_a.vs_i     = vs; if_b.vs_i = vs;
        if_a.freeze_i = frz; if_b.freeze_i = frz;
    endtask

    // One pixel strobe; outputs are sampled on the following falling edge.
    task automatic pix(input logic [9:0] h, input logic [9:0] v,
                       input logic blank, input logic hs, input logic vs, input logic frz);
        @(negedge clk);
        set_in(h, v, blank, hs, vs, frz);
        if_a.pix_en_i = 1'b1;
        if_b.pix_en_i = 1'b1;
        @(negedge clk);
        if_a.pix_en_i = 1'b0;
        if_b.pix_en_i = 1'b0;
    endtask

    task automatic frame_tick(input logic frz);
        pix(10'd700, 10'd500, 1'b1, 1'b1, 1'b0, frz);
        pix(10'd700, 10'd500, 1'b1, 1'b1, 1'b1, frz);
    endtask

    task automatic probe_a(input string tag, input logic [9:0] h, input logic [9:0] v,
                           input logic [11:0] exp);
        pix(h, v, 1'b0, 1'b1, 1'b1, 1'b0);
        check(tag, rgb_a, exp);
    endtask

    task automatic probe_b(input string tag, input logic [9:0] h, input logic [9:0] v,
                           input logic [11:0] exp);
        pix(h, v, 1'b0, 1'b1, 1'b1, 1'b0);
        check(tag, rgb_b, exp);
    endtask

    initial begin
        if_a.pix_en_i = 1'b0;
        if_b.pix_en_i = 1'b0;
        set_in(10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        check("rst_rgb", rgb_a, 12'h000);
        check("rst_hs", 12'(if_a.hs_o), 12'h1);
        check("rst_vs", 12'(if_a.vs_o), 12'h1);
        check("rst_cnt", 12'(if_a.bounce_cnt_o), 12'h0);
        rst = 1'b0;

        // Frozen frame: box stays at (0,0).
        frame_tick(1'b1);
        probe_a("box_00", 10'd0, 10'd0, 12'hFFF);
        probe_a("box_1919", 10'd19, 10'd19, 12'hFFF);
        probe_a("box_x20", 10'd20, 10'd5, 12'h000);
        probe_a("box_y20", 10'd5, 10'd20, 12'h000);
        pix(10'd10, 10'd10, 1'b1, 1'b1, 1'b1, 1'b0);
        check("blank_rgb", rgb_a, 12'h000);
        pix(10'd5, 10'd5, 1'b0, 1'b0, 1'b1, 1'b1);
        check("sync_rgb", rgb_a, 12'hFFF);
        check("sync_hs0", 12'(if_a.hs_o), 12'h0);
        check("sync_vs1", 12'(if_a.vs_o), 12'h1);
        pix(10'd30, 10'd5, 1'b0, 1'b1, 1'b0, 1'b1);
        check("sync_hs1", 12'(if_a.hs_o), 12'h1);
        check("sync_vs0", 12'(if_a.vs_o), 12'h0);
        pix(10'd30, 10'd5, 1'b0, 1'b1, 1'b1, 1'b1);
        check("sync_vs1b", 12'(if_a.vs_o), 12'h1);
        check("frz_cnt", 12'(if_a.bounce_cnt_o), 12'h0);
        probe_a("frz_00", 10'd0, 10'd0, 12'hFFF);

        // Free-running frames; the 64x64 instance corners at frame 56.
        for (int t = 1; t <= 620; t++) begin
            frame_tick(1'b0);
            if (t == 55) check("b_cnt55", 12'(if_b.bounce_cnt_o), 12'h0);
            if (t == 56) begin
                check("b_cnt56", 12'(if_b.bounce_cnt_o), 12'h1);
                probe_b("b56_in", 10'd56, 10'd56, 12'hFFF);
                probe_b("b56_lo", 10'd55, 10'd56, 12'h000);
                probe_b("b56_hi", 10'd63, 10'd63, 12'hFFF);
            end
            if (t == 57) begin
                check("b_cnt57", 12'(if_b.bounce_cnt_o), 12'h1);
                probe_b("b57_in", 10'd55, 10'd55, 12'hFFF);
                probe_b("b57_hi", 10'd63, 10'd63, 12'h000);
            end
            if (t == 459) check("a_cnt459", 12'(if_a.bounce_cnt_o), 12'h0);
            if (t == 460) begin
                check("a_cnt460", 12'(if_a.bounce_cnt_o), 12'h1);
                probe_a("a460_bot", 10'd460, 10'd479, 12'hFFF);
                probe_a("a460_top", 10'd460, 10'd459, 12'h000);
            end
            if (t == 619) check("a_cnt619", 12'(if_a.bounce_cnt_o), 12'h1);
        end
        check("a_cnt620", 12'(if_a.bounce_cnt_o), 12'h2);
        probe_a("f620_in", 10'd620, 10'd300, 12'hFFF);
        probe_a("f620_l", 10'd619, 10'd300, 12'h000);
        probe_a("f620_br", 10'd639, 10'd319, 12'hFFF);
        probe_a("f620_b", 10'd639, 10'd320, 12'h000);
        frame_tick(1'b0);
        probe_a("f621_in", 10'd619, 10'd299, 12'hFFF);
        probe_a("f621_l", 10'd618, 10'd299, 12'h000);
        probe_a("f621_br", 10'd638, 10'd318, 12'hFFF);
        probe_a("f621_r", 10'd639, 10'd318, 12'h000);
        check("a_cnt621", 12'(if_a.bounce_cnt_o), 12'h2);

        // Strobe gating: outputs hold and vs toggles between strobes do not tick.
        pix(10'd625, 10'd305, 1'b0, 1'b0, 1'b0, 1'b1);
        check("hold_rgb0", rgb_a, 12'hFFF);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            set_in(10'(i * 37), 10'(i * 41), i[0], ~i[0], i[0], i[0]);
            @(posedge clk);
            #1;
            check("hold_rgb", rgb_a, 12'hFFF);
            check("hold_hs", 12'(if_a.hs_o), 12'h0);
            check("hold_vs", 12'(if_a.vs_o), 12'h0);
            check("hold_cnt", 12'(if_a.bounce_cnt_o), 12'h2);
        end
        pix(10'd638, 10'd318, 1'b0, 1'b1, 1'b0, 1'b0);
        check("notick_rgb", rgb_a, 12'hFFF);
        pix(10'd700, 10'd500, 1'b1, 1'b1, 1'b1, 1'b0);
        probe_a("notick_r", 10'd639, 10'd318, 12'h000);

        // Screen outline pixels, clear of the box.
        probe_a("edge_l", 10'd0, 10'd100, EDGE_RGB);
        probe_a("edge_r", 10'd639, 10'd100, EDGE_RGB);
        probe_a("edge_t", 10'd100, 10'd0, EDGE_RGB);
        probe_a("edge_b", 10'd100, 10'd479, EDGE_RGB);

        // Asynchronous reset mid-line.
        pix(10'd625, 10'd305, 1'b0, 1'b0, 1'b0, 1'b1);
        check("pre_rst_rgb", rgb_a, 12'hFFF);
        check("pre_rst_hs", 12'(if_a.hs_o), 12'h0);
        @(negedge clk);
        set_in(10'd300, 10'd305, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("arst_rgb", rgb_a, 12'h000);
        check("arst_hs", 12'(if_a.hs_o), 12'h1);
        check("arst_vs", 12'(if_a.vs_o), 12'h1);
        check("arst_cnt", 12'(if_a.bounce_cnt_o), 12'h0);
        check("arst_cnt_b", 12'(if_b.bounce_cnt_o), 12'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        probe_a("rs_00", 10'd0, 10'd0, 12'hFFF);
        probe_a("rs_1919", 10'd19, 10'd19, 12'hFFF);
        probe_a("rs_x20", 10'd20, 10'd0, 12'h000);
        frame_tick(1'b0);
        probe_a("rs1_00", 10'd0, 10'd0, 12'h000);
        probe_a("rs1_11", 10'd1, 10'd1, 12'hFFF);
        probe_a("rs1_2020", 10'd20, 10'd20, 12'hFFF);
        probe_a("rs1_21", 10'd21, 10'd20, 12'h000);
        check("rs1_cnt", 12'(if_a.bounce_cnt_o), 12'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
